// File: rtl/pipelined_shifter.sv
// Pipelined four-mode barrel shifter (SLL/SRL/SRA/ROL) with valid/ready handshakes.
// One register stage per shift-amount bit, largest shift first; a tag rides along with each op.
module pipelined_shifter #(
  parameter  int WIDTH = 32,
  parameter  int TAG_W = 5,
  localparam int SH_W  = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SH_W-1:0]  in_shamt,
  input  logic [1:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
);

  localparam int L = SH_W;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROL = 2'b11
  } op_e;

  logic             valid_reg  [L];
  logic [WIDTH-1:0] data_reg   [L];
  logic [1:0]       op_reg     [L];
  logic             sign_reg   [L];
  logic [SH_W-1:0]  shamt_reg  [L];
  logic [TAG_W-1:0] tag_reg    [L];

  logic             valid_next [L];
  logic [WIDTH-1:0] data_next  [L];
  logic [1:0]       op_next    [L];
  logic             sign_next  [L];
  logic [SH_W-1:0]  shamt_next [L];
  logic [TAG_W-1:0] tag_next   [L];

  logic adv;

  assign adv      = ~valid_reg[L-1] | out_ready;
  assign in_ready = adv & ~flush;

  for (genvar gi = 0; gi < L; gi++) begin : g_stage
    localparam int S = 1 << (SH_W - 1 - gi);

    logic             v_src;
    logic [WIDTH-1:0] d_src;
    logic [1:0]       op_src;
    logic             sign_src;
    logic [SH_W-1:0]  sh_src;
    logic [TAG_W-1:0] t_src;
    logic [WIDTH-1:0] shifted;

    if (gi == 0) begin : g_src
      assign v_src    = in_valid & in_ready;
      assign d_src    = in_data;
      assign op_src   = in_op;
      assign sign_src = in_data[WIDTH-1];
      assign sh_src   = in_shamt;
      assign t_src    = in_tag;
    end else begin : g_src
      assign v_src    = valid_reg[gi-1];
      assign d_src    = data_reg[gi-1];
      assign op_src   = op_reg[gi-1];
      assign sign_src = sign_reg[gi-1];
      assign sh_src   = shamt_reg[gi-1];
      assign t_src    = tag_reg[gi-1];
    end

    always_comb begin
      shifted = d_src;
      case (op_src)
        OP_SLL:  shifted = d_src << S;
        OP_SRL:  shifted = d_src >> S;
        OP_SRA:  shifted = (d_src >> S) | ({WIDTH{sign_src}} << (WIDTH - S));
        default: shifted = (d_src << S) | (d_src >> (WIDTH - S));
      endcase
    end

    // The shift-amount MSB is consumed here; the rest moves up so the next stage reads its MSB.
    assign valid_next[gi] = v_src;
    assign data_next[gi]  = sh_src[SH_W-1] ? shifted : d_src;
    assign op_next[gi]    = op_src;
    assign sign_next[gi]  = sign_src;
    assign shamt_next[gi] = {sh_src[SH_W-2:0], 1'b0};
    assign tag_next[gi]   = t_src;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < L; i++) begin
        valid_reg[i] <= 1'b0;
        data_reg[i]  <= '0;
        op_reg[i]    <= '0;
        sign_reg[i]  <= 1'b0;
        shamt_reg[i] <= '0;
        tag_reg[i]   <= '0;
      end
    end else begin
      if (adv) begin
        for (int i = 0; i < L; i++) begin
          valid_reg[i] <= valid_next[i];
          data_reg[i]  <= data_next[i];
          op_reg[i]    <= op_next[i];
          sign_reg[i]  <= sign_next[i];
          shamt_reg[i] <= shamt_next[i];
          tag_reg[i]   <= tag_next[i];
        end
      end
      // A result retiring this cycle has already been taken by the consumer; the rest die.
      if (flush) begin
        for (int i = 0; i < L; i++) begin
          valid_reg[i] <= 1'b0;
        end
      end
    end
  end

  assign out_valid = valid_reg[L-1];
  assign out_data  = data_reg[L-1];
  assign out_tag   = tag_reg[L-1];

endmodule

// File: tb/tb_pipelined_shifter.sv
// Scoreboard bench for pipelined_shifter: directed cases at WIDTH=32 plus random sweeps at 8/16/64.
// Expected results come from an arithmetic reference model; a monitor per DUT pops and compares.
module tb_pipelined_shifter;

  localparam int NCFG = 4;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  function automatic logic [63:0] ref_shift(input logic [63:0] d_in, input int s,
                                            input logic [1:0] op, input int w);
    logic [63:0] mask;
    logic [63:0] d;
    logic [63:0] r;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    d = d_in & mask;
    case (op)
      2'd0: r = d << s;
      2'd1: r = d >> s;
      2'd2: begin
        r = d >> s;
        if (d[w-1]) r = r | (mask & ~(mask >> s));
      end
      default: r = (s == 0) ? d : ((d << s) | (d >> (w - s)));
    endcase
    return r & mask;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
    localparam int W  = (gi == 0) ? 32 : (gi == 1) ? 8 : (gi == 2) ? 16 : 64;
    localparam int TW = (gi == 0) ? 5 : 3;
    localparam int SW = $clog2(W);

    logic          reset     = 1'b1;
    logic          flush     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data   = '0;
    logic [SW-1:0] in_shamt  = '0;
    logic [1:0]    in_op     = '0;
    logic [TW-1:0] in_tag    = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out_data;
    logic [TW-1:0] out_tag;

    logic [W-1:0]  exp_drive = '0;
    logic          chk_lat   = 1'b0;
    logic          started   = 1'b0;
    logic          rnd_ready = 1'b0;
    logic          fin       = 1'b0;
    int            retired   = 0;

    logic [W-1:0]  q_d[$];
    logic [TW-1:0] q_t[$];
    int            q_acc[$];
    logic          q_lat[$];

    pipelined_shifter #(.WIDTH(W), .TAG_W(TW)) dut (
      .clock(clock), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_shamt(in_shamt), .in_op(in_op), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_tag(out_tag)
    );

    // Monitor: retirements are compared against the queue; transfers push the stimulus's expectation.
    initial begin
      logic          prev_stall;
      logic [W-1:0]  prev_d;
      logic [TW-1:0] prev_t;
      prev_stall = 1'b0;
      prev_d = '0;
      prev_t = '0;
      forever begin
        @(negedge clock);
        if (started) begin
          if (out_valid && !prev_stall && q_lat.size() > 0 && q_lat[0])
            check($sformatf("w%0d_latency", W), 64'(cyc - q_acc[0]), 64'(SW));
          if (out_valid && prev_stall) begin
            check($sformatf("w%0d_hold_data", W), 64'(out_data), 64'(prev_d));
            check($sformatf("w%0d_hold_tag", W), 64'(out_tag), 64'(prev_t));
          end
          if (out_valid && !out_ready)
            check($sformatf("w%0d_stall_in_ready", W), 64'(in_ready), 64'd0);
          if (out_valid && out_ready) begin
            if (q_d.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL w%0d_unexpected_output actual=%0h/%0h required=no output", W, out_data, out_tag);
            end else begin
              check($sformatf("w%0d_data", W), 64'(out_data), 64'(q_d[0]));
              check($sformatf("w%0d_tag", W), 64'(out_tag), 64'(q_t[0]));
              void'(q_d.pop_front());
              void'(q_t.pop_front());
              void'(q_acc.pop_front());
              void'(q_lat.pop_front());
              retired++;
            end
          end
          prev_stall = out_valid && !out_ready && !reset && !flush;
          prev_d = out_data;
          prev_t = out_tag;
        end
        if (reset || flush) begin
          q_d.delete();
          q_t.delete();
          q_acc.delete();
          q_lat.delete();
        end else if (in_valid && in_ready) begin
          q_d.push_back(exp_drive);
          q_t.push_back(in_tag);
          q_acc.push_back(cyc);
          q_lat.push_back(chk_lat);
        end
      end
    end

    initial begin
      forever begin
        @(posedge clock);
        #1;
        if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
      end
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic send(input logic [63:0] d, input int sh, input logic [1:0] op,
                        input logic [TW-1:0] t, input logic [63:0] e, input logic lat);
      int tmo;
      tmo = 0;
      in_valid  = 1'b1;
      in_data   = W'(d);
      in_shamt  = SW'(sh);
      in_op     = op;
      in_tag    = t;
      exp_drive = W'(e);
      chk_lat   = lat;
      @(negedge clock);
      while (!in_ready && tmo < 500) begin
        @(negedge clock);
        tmo++;
      end
      if (!in_ready) begin
        checks++;
        errors++;
        $display("FAIL w%0d_send_timeout actual=in_ready 0 required=in_ready 1", W);
      end
      @(posedge clock);
      #1;
      in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
      repeat (n) @(posedge clock);
      #1;
    endtask

    task automatic wait_idle();
      int tmo;
      tmo = 0;
      while ((q_d.size() != 0 || out_valid) && tmo < 3000) begin
        @(posedge clock);
        tmo++;
      end
      #1;
      check($sformatf("w%0d_drain_pending", W), 64'(q_d.size()), 64'd0);
    endtask

    task automatic send_random(input logic lat);
      logic [63:0] rd;
      int          sh;
      logic [1:0]  op;
      rd = {$urandom, $urandom};
      op = 2'($urandom_range(0, 3));
      sh = ($urandom_range(0, 5) == 0) ? W - 1 : int'($urandom_range(0, W - 1));
      send(rd, sh, op, TW'($urandom), ref_shift(rd, sh, op, W), lat);
    endtask

    task automatic do_reset();
      reset = 1'b1;
      idle(3);
      check($sformatf("w%0d_rst_out_valid", W), 64'(out_valid), 64'd0);
      check($sformatf("w%0d_rst_out_data", W), 64'(out_data), 64'd0);
      check($sformatf("w%0d_rst_out_tag", W), 64'(out_tag), 64'd0);
      reset = 1'b0;
      started = 1'b1;
    endtask

    if (gi == 0) begin : g_dir
      localparam logic [31:0] D1 [6] = '{32'h00000001, 32'h80000000, 32'h80000000,
                                         32'h7FFFFFF0, 32'h80000001, 32'h12345678};
      localparam int          S1 [6] = '{31, 31, 4, 4, 1, 16};
      localparam logic [1:0]  O1 [6] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
      localparam logic [31:0] E1 [6] = '{32'h80000000, 32'h00000001, 32'hF8000000,
                                         32'h07FFFFFF, 32'h00000003, 32'h56781234};
      initial begin
        int r0;
        int a;
        int tmo;
        do_reset();

        for (int i = 0; i < 6; i++)
          send(64'(D1[i]), S1[i], O1[i], TW'(i + 8), 64'(E1[i]), 1'b1);
        wait_idle();

        for (int i = 0; i < 4; i++)
          send(64'hDEADBEEF, 0, 2'(i), TW'(i + 1), 64'hDEADBEEF, 1'b1);
        wait_idle();

        // Freeze the pipe for 3 cycles starting with the cycle the first result appears.
        r0 = retired;
        a = 0;
        tmo = 0;
        fork
          begin
            for (int i = 0; i < 8; i++) send_random(1'b0);
          end
          begin
            @(negedge clock);
            while (!(in_valid && in_ready) && tmo < 100) begin
              @(negedge clock);
              tmo++;
            end
            a = cyc;
            while (cyc < a + SW && tmo < 200) begin
              @(posedge clock);
              #1;
              tmo++;
            end
            out_ready = 1'b0;
            idle(3);
            out_ready = 1'b1;
          end
        join
        wait_idle();
        check("w32_stall_retired", 64'(retired - r0), 64'd8);

        r0 = retired;
        for (int i = 0; i < 3; i++)
          send(64'h0000_00F0 + 64'(i), i + 1, 2'd0, TW'(i + 20), 64'hBAD, 1'b0);
        in_valid  = 1'b1;
        in_data   = 32'hCAFEF00D;
        in_shamt  = 5'd3;
        in_op     = 2'd1;
        in_tag    = 5'd30;
        exp_drive = 32'hBAD;
        flush     = 1'b1;
        @(negedge clock);
        check("w32_flush_in_ready", 64'(in_ready), 64'd0);
        @(posedge clock);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        idle(10);
        check("w32_flush_no_output", 64'(retired - r0), 64'd0);
        send(64'h0F0F0F0F, 4, 2'd0, TW'(7), 64'hF0F0F0F0, 1'b1);
        wait_idle();
        check("w32_post_flush_retired", 64'(retired - r0), 64'd1);

        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_random(1'b0);
        reset = 1'b1;
        idle(1);
        check("w32_midrst_out_valid", 64'(out_valid), 64'd0);
        check("w32_midrst_out_data", 64'(out_data), 64'd0);
        check("w32_midrst_out_tag", 64'(out_tag), 64'd0);
        reset = 1'b0;
        @(negedge clock);
        check("w32_midrst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clock);
        #1;
        out_ready = 1'b1;

        r0 = retired;
        rnd_ready = 1'b1;
        for (int i = 0; i < 150; i++) begin
          send_random(1'b0);
          if ($urandom_range(0, 3) == 0) idle(1);
        end
        rnd_ready = 1'b0;
        out_ready = 1'b1;
        wait_idle();
        check("w32_random_retired", 64'(retired - r0), 64'd150);
        fin = 1'b1;
      end
    end else begin : g_sweep
      initial begin
        int r0;
        do_reset();
        r0 = retired;
        for (int op = 0; op < 4; op++) begin
          logic [63:0] rd;
          rd = {$urandom, $urandom};
          send(rd, W - 1, 2'(op), TW'(op), ref_shift(rd, W - 1, 2'(op), W), 1'b1);
        end
        for (int i = 0; i < 40; i++) send_random(1'b1);
        wait_idle();
        rnd_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
          send_random(1'b0);
          if ($urandom_range(0, 4) == 0) idle(1);
        end
        rnd_ready = 1'b0;
        out_ready = 1'b1;
        wait_idle();
        check($sformatf("w%0d_retired", W), 64'(retired - r0), 64'd144);
        fin = 1'b1;
      end
    end
  end

  initial begin
    int tmo;
    tmo = 0;
    while (!(g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin && g_cfg[3].fin) && tmo < 60000) begin
      @(posedge clock);
      tmo++;
    end
    if (tmo >= 60000) begin
      checks++;
      errors++;
      $display("FAIL global_timeout actual=%0d cycles required=all configurations done", tmo);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipelined_shifter.md
Name: pipelined_shifter

Overview:
- Parametrised, pipelined successor to the ALU's 32-bit left-only barrel shifter.
- Supports four shift modes (SLL, SRL, SRA, ROL) at any power-of-two width.
- Registers each log2 shift stage and uses valid/ready handshakes, so the processor's execute stage can issue one shift per cycle and stall cleanly.
- Carries a tag (destination register index) alongside the data for writeback tracking.

Parameters:
- WIDTH, 32: data width; power of two, >= 4.
- TAG_W, 5: width of the sideband tag carried with each operation.
- SH_W, log2(WIDTH) (derived, not overridable): shift-amount width and pipeline depth L.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  synchronous pipeline kill; discards all in-flight ops.
- in_valid  input  1  an operation is presented.
- in_ready  output  1  the block accepts the operation this cycle.
- in_data  input  WIDTH  operand.
- in_shamt  input  SH_W  shift amount, unsigned, 0..WIDTH-1.
- in_op  input  2  mode: 00 SLL, 01 SRL, 10 SRA, 11 ROL.
- in_tag  input  TAG_W  sideband tag, returned unmodified.
- out_valid  output  1  result is available.
- out_ready  input  1  consumer takes the result this cycle.
- out_data  output  WIDTH  shifted result.
- out_tag  output  TAG_W  tag of the result.

Behaviour:
- Structure: L = SH_W register stages. Stage k (k = 0..L-1) applies shift 2^(SH_W-1-k) when the corresponding shamt bit is 1, so the largest shift comes first.
- Each stage register holds: valid, data, op, remaining shamt bits, tag. The last stage drives out_valid, out_data and out_tag directly from registers.
- Global advance: adv = ~out_valid | out_ready. On adv, every stage loads from its predecessor. Stage 0 loads from the inputs, with valid = in_valid & in_ready.
- When adv = 0, all stage registers hold their values.
- Bubbles also advance, so there is no internal compaction.
- in_ready = adv & ~flush (combinational).
- A transfer occurs when in_valid & in_ready; results retire when out_valid & out_ready.
- Latency: a result accepted in cycle N has out_valid high in cycle N+L if there are no stalls.
- Throughput: 1 op/cycle. Up to L ops in flight. Order is strictly preserved.
- Stage functions (shift by s):
  - SLL: zero fill from the LSB side.
  - SRL: zero fill from the MSB side.
  - SRA: fill with the original operand MSB. The sign bit is captured at stage 0 and carried down the pipeline.
  - ROL: bits shifted out of the MSB re-enter at the LSB.
- shamt = 0: out_data = in_data for all modes.
- The shift-amount width is exactly SH_W, so amounts >= WIDTH cannot be expressed. No saturation logic is required.
- Reset (synchronous, highest priority): all valid bits 0, all data/tag/op/shamt registers 0. Therefore out_valid = 0, out_data = 0, out_tag = 0 in the cycle after reset is sampled high.
- Reset mid-operation discards all in-flight ops, with no partial output.
- Flush (when reset = 0): all valid bits are cleared at the next edge. Data registers may keep stale values but are never presented as valid.
- An op presented in the same cycle as flush is not accepted (in_ready = 0).
- Flush with out_valid & out_ready high: that retirement completes in this cycle. The retiring result is not lost; everything behind it is killed.
- Backpressure: with out_ready = 0 and out_valid = 1, the whole pipe freezes and in_ready = 0.
- The inputs must not be required to stay stable while in_ready = 0. The sender holds them per the valid/ready rule.
- Stall release: with out_ready returning high, the pipe advances in that same cycle. There is no bubble penalty.
- No combinational path from in_* to out_*. The only combinational path to an output is out_ready/flush to in_ready.

Test Plan:
- Reset, then back-to-back issue (WIDTH=32) -> each result appears exactly 5 cycles after its accept, in issue order:
  - SLL 0x00000001 by 31 -> 0x80000000
  - SRL 0x80000000 by 31 -> 0x00000001
  - SRA 0x80000000 by 4 -> 0xF8000000
  - SRA 0x7FFFFFF0 by 4 -> 0x07FFFFFF
  - ROL 0x80000001 by 1 -> 0x00000003
  - ROL 0x12345678 by 16 -> 0x56781234
- shamt = 0 in all four modes on 0xDEADBEEF -> 0xDEADBEEF each time, with tags 1..4 returned in order.
- Issue 8 consecutive ops; hold out_ready = 0 from the cycle the first result is valid, for 3 cycles -> in_ready = 0 during the stall, out_data/out_tag stable, no op lost or duplicated, all 8 results correct and in order after release.
- Issue 3 ops, assert flush one cycle with in_valid = 1 -> no results emerge, the flush-cycle op is not accepted, and the next op issued afterwards emerges 5 cycles after its accept with the correct value.
- Assert reset while 4 ops are in flight and out_ready = 0 -> the next cycle shows out_valid = 0, out_data = 0, out_tag = 0, and in_ready = 1 after reset deasserts.
- Parameter sweep WIDTH = 8, 16, 64 (TAG_W = 3) with random ops checked against a reference model, including shamt = WIDTH-1 -> all results match, and latency equals log2(WIDTH).
